encoder_4to2_pending: RTL and testbench

//  Inverse of decoder_2to4_onehot: turns request events on a one-hot/multi-hot

---
 rtl/encoder_4to2_pending_if.sv | 15 +
 rtl/encoder_4to2_pending.sv | 46 ++++
 tb/tb_encoder_4to2_pending.sv | 132 +++++++++++++
 3 files changed

// File: rtl/encoder_4to2_pending_if.sv
// encoder_4to2_pending_if: request inputs and valid/ready index output of the pending encoder
interface encoder_4to2_pending_if #(
  parameter int N = 4,
  parameter int IDX_W = 2
);
  logic en;
  logic [N-1:0] req;
  logic ready;
  logic valid_o;
  logic [IDX_W-1:0] idx_o;
  logic [N-1:0] pending;
  logic ovf;
  modport master (output en, req, ready, input valid_o, idx_o, pending, ovf);
  modport slave (input en, req, ready, output valid_o, idx_o, pending, ovf);
endinterface

// File: rtl/encoder_4to2_pending.sv
// encoder_4to2_pending: latches request pulses and drains them as indices, lowest index first
module encoder_4to2_pending #(
  parameter int N = 4,
  parameter int IDX_W = 2
) (
  input logic clk,
  input logic rst,
  encoder_4to2_pending_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_next;
  logic [N-1:0] pend, pend_next, take, set;
  logic [IDX_W-1:0] idx, idx_next, hi;
  logic ovf, slot_free, load;
  // req MSB is index 0, so the highest set bit wins
  always_comb begin
    hi = '0;
    for (int b = 0; b < N; b++) if (pend[b]) hi = IDX_W'(b);
  end
  always_comb begin
    slot_free = state == EMPTY || bus.ready;
    load = slot_free && |pend;
    state_next = load ? FULL : slot_free ? EMPTY : state;
    idx_next = IDX_W'(N - 1) - hi;
    take = load ? N'(1) << hi : '0;
    set = {N{bus.en}} & bus.req;
    pend_next = (pend & ~take) | set;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      idx <= '0;
      pend <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_next;
      if (load) idx <= idx_next;
      pend <= pend_next;
      ovf <= ovf | (|(set & pend & ~take));
    end
  end
  assign bus.valid_o = state == FULL;
  assign bus.idx_o = idx;
  assign bus.pending = pend;
  assign bus.ovf = ovf;
endmodule

// File: tb/tb_encoder_4to2_pending.sv
// tb_encoder_4to2_pending: directed and random stimulus checked against an index-level model
module tb_encoder_4to2_pending;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_pend [N];
  bit m_valid;
  int m_idx;
  bit m_ovf;
  encoder_4to2_pending_if #(.N(N), .IDX_W(2)) bus ();
  encoder_4to2_pending #(.N(N), .IDX_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // model works in index space: m_pend[i] means index i is waiting
  task automatic model_step();
    int first;
    int taken;
    bit nxt [N];
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_valid = 0;
      m_idx = 0;
      m_ovf = 0;
      return;
    end
    first = -1;
    taken = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) first = i;
    if (!m_valid || bus.ready) begin
      if (first >= 0) begin
        m_idx = first;
        m_valid = 1;
        taken = first;
      end else m_valid = 0;
    end
    for (int i = 0; i < N; i++) begin
      bit s;
      s = bus.en && bus.req[N-1-i];
      if (s && m_pend[i] && i != taken) m_ovf = 1;
      nxt[i] = (m_pend[i] && i != taken) || s;
    end
    m_pend = nxt;
  endtask
  task automatic tick(input logic r, input logic e, input logic [N-1:0] q, input logic rd);
    logic [N-1:0] ep;
    rst = r;
    bus.en = e;
    bus.req = q;
    bus.ready = rd;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) ep[N-1-i] = m_pend[i];
    chk("valid", 32'(bus.valid_o), 32'(m_valid));
    chk("idx", 32'(bus.idx_o), 32'(m_idx));
    chk("pending", 32'(bus.pending), 32'(ep));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.req = '0;
    bus.ready = 1'b0;
    // reset drops requests
    tick(1, 1, 4'b1111, 1);
    tick(1, 1, 4'b1111, 1);
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_pending", 32'(bus.pending), 0);
    tick(0, 0, 4'b0000, 1);
    chk("rst_ovf", 32'(bus.ovf), 0);
    // single request: visible two edges after sampling
    tick(0, 1, 4'b0100, 1);
    chk("t2_notyet", 32'(bus.valid_o), 0);
    tick(0, 1, 4'b0000, 1);
    chk("t2_valid", 32'(bus.valid_o), 1);
    chk("t2_idx", 32'(bus.idx_o), 1);
    chk("t2_pend", 32'(bus.pending), 0);
    tick(0, 1, 4'b0000, 1);
    chk("t2_drop", 32'(bus.valid_o), 0);
    // multi-hot drains in priority order
    tick(0, 1, 4'b1011, 1);
    tick(0, 1, 4'b0000, 1);
    chk("t3_a", 32'(bus.idx_o), 0);
    tick(0, 1, 4'b0000, 1);
    chk("t3_b", 32'(bus.idx_o), 2);
    tick(0, 1, 4'b0000, 1);
    chk("t3_c", 32'(bus.idx_o), 3);
    tick(0, 1, 4'b0000, 1);
    chk("t3_end", 32'(bus.valid_o), 0);
    // back-pressure holds the slot
    tick(0, 1, 4'b0011, 0);
    for (int k = 0; k < 6; k++) tick(0, 1, 4'b0000, 0);
    chk("t4_idx", 32'(bus.idx_o), 2);
    chk("t4_pend", 32'(bus.pending), 1);
    tick(0, 1, 4'b0000, 1);
    chk("t4_next", 32'(bus.idx_o), 3);
    tick(0, 1, 4'b0000, 1);
    tick(0, 1, 4'b0000, 1);
    // merged request sets ovf
    tick(0, 1, 4'b1000, 0);
    tick(0, 1, 4'b0001, 0);
    tick(0, 1, 4'b0001, 0);
    chk("t5_ovf", 32'(bus.ovf), 1);
    tick(0, 1, 4'b0000, 1);
    chk("t5_a", 32'(bus.idx_o), 3);
    tick(0, 1, 4'b0000, 1);
    chk("t5_b", 32'(bus.valid_o), 0);
    tick(1, 0, 4'b0000, 1);
    // re-request on the load cycle is emitted again without ovf
    tick(0, 1, 4'b0010, 1);
    tick(0, 1, 4'b0010, 1);
    chk("t6_a", 32'(bus.idx_o), 2);
    tick(0, 1, 4'b0000, 1);
    chk("t6_b", 32'(bus.valid_o), 1);
    chk("t6_ovf", 32'(bus.ovf), 0);
    tick(1, 1, 4'b0000, 1);
    chk("t6_rst", 32'(bus.valid_o), 0);
    for (int k = 0; k < 400; k++)
      tick($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, $urandom_range(0, 2) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
